// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  ofs,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ofs)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = ofs[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay right-justified store data onto the old word, keeping other lanes.
  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  ofs,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: begin
        case (ofs)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (ofs[1]) r[31:16] = data[15:0];
        else        r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  // Illegal size, misalignment or word index beyond the attached memory.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input logic [1:0]  size,
                                      input int unsigned mem_words);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= mem_words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-addressed memory port of the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // Environment side: pipeline requester and the memory.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr, mem_wdata, mem_write
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  // Both views are derived from the same freshly read word.
  always_comb begin
    ld_data_o = extend_load(rd_word_i, addr_lo_i, size_i, signed_i);
    st_word_o = merge_store(rd_word_i, st_data_i, addr_lo_i, size_i);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: FSM and registers driving a word-addressed memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  lsu_state_t  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        req_err;

  lsu_lane_align u_align (
    .rd_word_i (bus.mem_rdata),
    .addr_lo_i (addr_lo_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .st_data_i (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  assign req_err = addr_error(bus.req_addr, bus.req_size, MEM_WORDS);

  // Next-state and datapath updates for one transaction at a time.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          signed_d   = bus.req_signed;
          addr_lo_d  = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata;
          mem_addr_d = {2'b00, bus.req_addr[31:2]};
          rdata_d    = '0;
          error_d    = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (bus.req_write && bus.req_size == SZ_WORD) begin
            // Whole-word stores need no read, so the word goes out directly.
            mem_wdata_d = bus.req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = st_word;
          state_d     = WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = RESP;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      default: begin
        if (bus.resp_ready) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  // Handshakes and the write strobe decode straight from state, so reset drops them at once.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.mem_write  = (state_q == WRITE);
    bus.resp_rdata = rdata_q;
    bus.resp_error = error_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
  end

endmodule
